// File: rtl/ad_uart_pkg.sv
// ad_uart_pkg: shared state encoding, ASCII constants and frame length helper
package ad_uart_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    localparam logic [7:0] CH_C     = 8'h43;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_QMARK = 8'h3F;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    function automatic int frame_len(input bit send_crlf);
        return send_crlf ? 8 : 6;
    endfunction
endpackage

// File: rtl/nibble_to_ascii.sv
// nibble_to_ascii: maps a nibble to its hex character, or to a decimal digit with '?' for non-BCD values
module nibble_to_ascii
    import ad_uart_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [7:0] ascii
);
    assign ascii = (nibble < 4'd10) ? CH_ZERO + {4'd0, nibble} :
                   hex_mode         ? CH_A + {4'd0, nibble} - 8'd10 : CH_QMARK;
endmodule

// File: rtl/ad_uart_framer.sv
// ad_uart_framer: turns each AD sample into a "Cn:ddd\r\n" text line streamed to the UART transmitter
module ad_uart_framer
    import ad_uart_pkg::*;
#(
    parameter int DECIMATE  = 1,
    parameter bit SEND_CRLF = 1
) (
    input  logic        Sys_CLK,
    input  logic        Sys_RST,
    input  logic        Sample_Valid,
    input  logic [11:0] Sample_BCD,
    input  logic [3:0]  Sample_Addr,
    output logic        Sample_Ready,
    output logic [7:0]  Tx_Data,
    output logic        Tx_Valid,
    input  logic        Tx_Ready,
    output logic        Frame_Busy,
    output logic [7:0]  Drop_Cnt
);
    localparam logic [2:0] LAST     = 3'(frame_len(SEND_CRLF) - 1);
    localparam logic [7:0] DEC_LAST = 8'(DECIMATE - 1);

    state_t      state, state_nx;
    logic [7:0]  dec_cnt, drop_cnt;
    logic [2:0]  idx;
    logic [11:0] bcd_q;
    logic [3:0]  addr_q;
    logic [7:0]  ch_addr, ch_h, ch_t, ch_u, frame_byte;
    logic        capture, xfer, last;

    assign capture  = state == IDLE && Sample_Valid && dec_cnt == 8'd0;
    assign xfer     = state == SEND && Tx_Ready;
    assign last     = idx == LAST;
    assign Drop_Cnt = drop_cnt;

    nibble_to_ascii u_addr (.nibble(addr_q),      .hex_mode(1'b1), .ascii(ch_addr));
    nibble_to_ascii u_hund (.nibble(bcd_q[11:8]), .hex_mode(1'b0), .ascii(ch_h));
    nibble_to_ascii u_tens (.nibble(bcd_q[7:4]),  .hex_mode(1'b0), .ascii(ch_t));
    nibble_to_ascii u_unit (.nibble(bcd_q[3:0]),  .hex_mode(1'b0), .ascii(ch_u));

    // State register; reset abandons any partial frame
    always_ff @(posedge Sys_CLK) begin
        state <= Sys_RST ? IDLE : state_nx;
    end

    // Enter SEND on a captured sample, leave on the transfer of the last byte
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = capture ? SEND : IDLE;
        else
            state_nx = (xfer && last) ? IDLE : SEND;
    end

    // Handshake outputs and current frame byte, driven only while sending
    always_comb begin
        Sample_Ready = state == IDLE;
        Frame_Busy   = state == SEND;
        Tx_Valid     = state == SEND;
        Tx_Data      = state == SEND ? frame_byte : 8'h00;
    end

    // Select the byte at the current index from the latched sample
    always_comb begin
        case (idx)
            3'd0:    frame_byte = CH_C;
            3'd1:    frame_byte = ch_addr;
            3'd2:    frame_byte = CH_COLON;
            3'd3:    frame_byte = ch_h;
            3'd4:    frame_byte = ch_t;
            3'd5:    frame_byte = ch_u;
            3'd6:    frame_byte = CH_CR;
            default: frame_byte = CH_LF;
        endcase
    end

    // Decimation, drop counting, sample latch and byte index
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            dec_cnt  <= '0;
            drop_cnt <= '0;
            idx      <= '0;
            bcd_q    <= '0;
            addr_q   <= '0;
        end else begin
            if (state == IDLE && Sample_Valid)
                dec_cnt <= dec_cnt == DEC_LAST ? 8'd0 : dec_cnt + 8'd1;
            if (state == SEND && Sample_Valid && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            if (capture) begin
                bcd_q  <= Sample_BCD;
                addr_q <= Sample_Addr;
                idx    <= '0;
            end else if (xfer) begin
                idx <= last ? 3'd0 : idx + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_ad_uart_framer.sv
// tb_ad_uart_framer: scoreboard bench for the AD-to-UART text framer
module tb_ad_uart_framer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sv_a = 0, tr_a = 0, sr_a, tv_a, busy_a;
    logic [11:0] bcd_a = 0;
    logic [3:0]  addr_a = 0;
    logic [7:0]  td_a, drop_a;
    logic        sv_b = 0, tr_b = 0, sr_b, tv_b, busy_b;
    logic [11:0] bcd_b = 0;
    logic [3:0]  addr_b = 0;
    logic [7:0]  td_b, drop_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] exp_a[$], exp_b[$], rx_a[$], rx_b[$];
    int rc_a[$];

    ad_uart_framer #(.DECIMATE(1), .SEND_CRLF(1)) u_a (
        .Sys_CLK(clk), .Sys_RST(rst), .Sample_Valid(sv_a), .Sample_BCD(bcd_a),
        .Sample_Addr(addr_a), .Sample_Ready(sr_a), .Tx_Data(td_a), .Tx_Valid(tv_a),
        .Tx_Ready(tr_a), .Frame_Busy(busy_a), .Drop_Cnt(drop_a));

    ad_uart_framer #(.DECIMATE(4), .SEND_CRLF(0)) u_b (
        .Sys_CLK(clk), .Sys_RST(rst), .Sample_Valid(sv_b), .Sample_BCD(bcd_b),
        .Sample_Addr(addr_b), .Sample_Ready(sr_b), .Tx_Data(td_b), .Tx_Valid(tv_b),
        .Tx_Ready(tr_b), .Frame_Busy(busy_b), .Drop_Cnt(drop_b));

    always @(posedge clk) cyc <= cyc + 1;

    // Record every byte that will transfer on the coming edge
    always @(negedge clk) begin
        if (!rst && tv_a && tr_a) begin
            rx_a.push_back(td_a);
            rc_a.push_back(cyc);
        end
        if (!rst && tv_b && tr_b) rx_b.push_back(td_b);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit b, input logic [11:0] bcd, input logic [3:0] addr);
        string hx = "0123456789ABCDEF";
        logic [7:0] f[8];
        f[0] = "C";
        f[1] = hx[addr];
        f[2] = ":";
        for (int d = 0; d < 3; d++)
            f[3+d] = (bcd[11-4*d -: 4] > 4'd9) ? "?" : hx[bcd[11-4*d -: 4]];
        f[6] = 8'h0D;
        f[7] = 8'h0A;
        for (int i = 0; i < (b ? 6 : 8); i++)
            if (b) exp_b.push_back(f[i]); else exp_a.push_back(f[i]);
    endtask

    task automatic strobe(input bit b, input logic [11:0] bcd, input logic [3:0] addr);
        if (b) begin sv_b = 1; bcd_b = bcd; addr_b = addr; end
        else   begin sv_a = 1; bcd_a = bcd; addr_a = addr; end
        step();
        sv_a = 0; sv_b = 0;
        bcd_a = ~bcd; addr_a = ~addr; bcd_b = ~bcd; addr_b = ~addr;
    endtask

    task automatic wait_idle(input bit b, input int lim, output bit ok);
        for (int i = 0; i < lim; i++) begin
            if (!(b ? busy_b : busy_a)) break;
            step();
        end
        ok = !(b ? busy_b : busy_a);
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (tv_a !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tv_a); end
        checks++; if (td_a !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", td_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        checks++; if (drop_a !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_a); end
        checks++; if (sr_a !== 1'b1 || sr_b !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b%b exp=11", sr_a, sr_b); end
        rst = 0;
        step();
    endtask

    task automatic test_basic();
        int cap;
        bit ok;
        tr_a = 1;
        push_exp(0, 12'h407, 4'h3);
        strobe(0, 12'h407, 4'h3);
        cap = cyc;
        checks++; if (tv_a !== 1'b1 || td_a !== 8'h43) begin failures++; $display("FAIL basic_latency got=%b/%h exp=1/43", tv_a, td_a); end
        checks++; if (sr_a !== 1'b0) begin failures++; $display("FAIL basic_ready_busy got=%b exp=0", sr_a); end
        wait_idle(0, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=busy exp=idle"); end
        checks++; if (sr_a !== 1'b1 || tv_a !== 1'b0) begin failures++; $display("FAIL basic_ready_after got=%b/%b exp=1/0", sr_a, tv_a); end
        checks++;
        if (rc_a.size() != 8 || rc_a[0] != cap || rc_a[7] != cap + 7) begin
            failures++; $display("FAIL basic_timing got=%0d bytes exp=8 consecutive from %0d", rc_a.size(), cap);
        end
        checks++; if (rx_a.size() != exp_a.size()) begin failures++; $display("FAIL basic_len got=%0d exp=%0d", rx_a.size(), exp_a.size()); end
        while (rx_a.size() > 0 && exp_a.size() > 0) begin
            logic [7:0] g = rx_a.pop_front();
            logic [7:0] e = exp_a.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL basic_byte got=%h exp=%h", g, e); end
        end
        rx_a.delete(); exp_a.delete(); rc_a.delete();
    endtask

    task automatic test_backpressure();
        bit prev_stall = 0;
        logic [7:0] prev_d = 0;
        push_exp(0, 12'h407, 4'h3);
        strobe(0, 12'h407, 4'h3);
        for (int i = 0; i < 60 && busy_a; i++) begin
            tr_a = (i % 3 == 0);
            if (prev_stall) begin
                checks++; if (td_a !== prev_d) begin failures++; $display("FAIL bp_stable got=%h exp=%h", td_a, prev_d); end
            end
            prev_stall = tv_a && !tr_a;
            prev_d = td_a;
            step();
        end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL bp_timeout got=busy exp=idle"); end
        checks++; if (rx_a.size() != exp_a.size()) begin failures++; $display("FAIL bp_len got=%0d exp=%0d", rx_a.size(), exp_a.size()); end
        while (rx_a.size() > 0 && exp_a.size() > 0) begin
            logic [7:0] g = rx_a.pop_front();
            logic [7:0] e = exp_a.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL bp_byte got=%h exp=%h", g, e); end
        end
        rx_a.delete(); exp_a.delete(); rc_a.delete();
        tr_a = 1;
    endtask

    task automatic test_hex_invalid();
        bit ok;
        tr_b = 1;
        push_exp(1, 12'h9A5, 4'hB);
        strobe(1, 12'h9A5, 4'hB);
        wait_idle(1, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL hex_timeout got=busy exp=idle"); end
        checks++; if (rx_b.size() != 6) begin failures++; $display("FAIL hex_len got=%0d exp=6", rx_b.size()); end
        while (rx_b.size() > 0 && exp_b.size() > 0) begin
            logic [7:0] g = rx_b.pop_front();
            logic [7:0] e = exp_b.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL hex_byte got=%h exp=%h", g, e); end
        end
        rx_b.delete(); exp_b.delete();
    endtask

    task automatic test_decimation();
        int dc = 0;
        bit ok;
        rst = 1; step(); rst = 0;
        rx_a.delete(); rc_a.delete();
        for (int i = 0; i < 8; i++) begin
            logic [11:0] bcd = {4'(i), 4'(i + 1), 4'(9 - i)};
            if (dc == 0) push_exp(1, bcd, 4'(i + 2));
            dc = (dc + 1) % 4;
            strobe(1, bcd, 4'(i + 2));
            wait_idle(1, 20, ok);
            checks++; if (!ok) begin failures++; $display("FAIL dec_timeout got=busy exp=idle at %0d", i); end
        end
        checks++; if (rx_b.size() != 12) begin failures++; $display("FAIL dec_bytes got=%0d exp=12", rx_b.size()); end
        checks++; if (drop_b !== 8'd0) begin failures++; $display("FAIL dec_drop got=%0d exp=0", drop_b); end
        while (rx_b.size() > 0 && exp_b.size() > 0) begin
            logic [7:0] g = rx_b.pop_front();
            logic [7:0] e = exp_b.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL dec_byte got=%h exp=%h", g, e); end
        end
        rx_b.delete(); exp_b.delete();
    endtask

    task automatic test_drops();
        bit ok;
        tr_a = 1;
        push_exp(0, 12'h123, 4'h0);
        strobe(0, 12'h123, 4'h0);
        repeat (7) step();
        sv_a = 1;
        step();
        sv_a = 0;
        checks++; if (drop_a !== 8'd1) begin failures++; $display("FAIL drop_last_edge got=%0d exp=1", drop_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL drop_idle got=%b exp=0", busy_a); end
        step();
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL drop_not_captured got=%b exp=0", busy_a); end
        tr_a = 0;
        push_exp(0, 12'h555, 4'h5);
        strobe(0, 12'h555, 4'h5);
        sv_a = 1;
        repeat (300) step();
        sv_a = 0;
        checks++; if (drop_a !== 8'd255) begin failures++; $display("FAIL drop_saturate got=%0d exp=255", drop_a); end
        checks++; if (tv_a !== 1'b1 || td_a !== 8'h43) begin failures++; $display("FAIL drop_stalled got=%b/%h exp=1/43", tv_a, td_a); end
        tr_a = 1;
        wait_idle(0, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL drop_timeout got=busy exp=idle"); end
        checks++; if (rx_a.size() != exp_a.size()) begin failures++; $display("FAIL drop_len got=%0d exp=%0d", rx_a.size(), exp_a.size()); end
        while (rx_a.size() > 0 && exp_a.size() > 0) begin
            logic [7:0] g = rx_a.pop_front();
            logic [7:0] e = exp_a.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL drop_byte got=%h exp=%h", g, e); end
        end
        rx_a.delete(); exp_a.delete(); rc_a.delete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        tr_a = 1;
        push_exp(0, 12'h861, 4'h7);
        while (exp_a.size() > 3) void'(exp_a.pop_back());
        strobe(0, 12'h861, 4'h7);
        repeat (3) step();
        rst = 1;
        step();
        rst = 0;
        checks++; if (tv_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b/%b exp=0/0", tv_a, busy_a); end
        checks++; if (drop_a !== 8'd0) begin failures++; $display("FAIL rstmid_drop got=%0d exp=0", drop_a); end
        step();
        checks++; if (tv_a !== 1'b0) begin failures++; $display("FAIL rstmid_quiet got=%b exp=0", tv_a); end
        push_exp(0, 12'h250, 4'hE);
        strobe(0, 12'h250, 4'hE);
        checks++; if (td_a !== 8'h43) begin failures++; $display("FAIL rstmid_fresh got=%h exp=43", td_a); end
        wait_idle(0, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout got=busy exp=idle"); end
        checks++; if (rx_a.size() != 11) begin failures++; $display("FAIL rstmid_len got=%0d exp=11", rx_a.size()); end
        while (rx_a.size() > 0 && exp_a.size() > 0) begin
            logic [7:0] g = rx_a.pop_front();
            logic [7:0] e = exp_a.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL rstmid_byte got=%h exp=%h", g, e); end
        end
        rx_a.delete(); exp_a.delete(); rc_a.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_hex_invalid();
        test_decimation();
        test_drops();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
